// File: rtl/iter_seq_ctrl_pkg.sv
// Shared definitions for the iteration sequencer.
// Index width, watchdog default and FSM state encoding.
package iter_seq_ctrl_pkg;

  localparam int MW_DEF     = 5;
  localparam int TO_CYC_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/iter_seq_ctrl_iter_cnt.sv
// Iteration index register for the sequencer.
// Clear has priority over increment.
module iter_cnt #(
  parameter int MW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [MW-1:0] val
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val <= '0;
    end else if (clr) begin
      val <= '0;
    end else if (inc) begin
      val <= val + MW'(1);
    end
  end

endmodule

// File: rtl/iter_seq_ctrl.sv
// Iteration sequencer issuing j = 0..M to the equality comparator.
// Optional WAIT watchdog: define ITER_TIMEOUT_EN.
module iter_seq_ctrl
  import iter_seq_ctrl_pkg::*;
#(
  parameter int MW = MW_DEF
`ifdef ITER_TIMEOUT_EN
  ,
  parameter int TO_CYC = TO_CYC_DEF
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [MW-1:0] m_in,
  input  logic          eq_out,
  input  logic          eq_valid,
  output logic          en,
  output logic [MW-1:0] j,
  output logic [MW-1:0] M,
  output logic          busy,
  output logic          step,
  output logic [MW-1:0] step_idx,
  output logic          done,
  output logic          err
);

  state_t        state, state_n;
  logic          en_n, busy_n, step_n, done_n;
  logic [MW-1:0] m_n, idx_n;
  logic          clr, inc;

`ifdef ITER_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] to_cnt, to_n;
  logic          err_n;
`endif

  iter_cnt #(.MW(MW)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (inc),
    .val   (j)
  );

  always_comb begin
    state_n = state;
    en_n    = en;
    m_n     = M;
    busy_n  = busy;
    step_n  = 1'b0;
    idx_n   = step_idx;
    done_n  = 1'b0;
    clr     = 1'b0;
    inc     = 1'b0;
`ifdef ITER_TIMEOUT_EN
    err_n   = err;
    to_n    = '0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          m_n     = m_in;
          clr     = 1'b1;
          en_n    = 1'b1;
          busy_n  = 1'b1;
          state_n = ST_ISSUE;
`ifdef ITER_TIMEOUT_EN
          err_n   = 1'b0;
`endif
        end
      end
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT: begin
        if (eq_valid) begin
          step_n = 1'b1;
          idx_n  = j;
          if (eq_out) begin
            done_n  = 1'b1;
            en_n    = 1'b0;
            busy_n  = 1'b0;
            state_n = ST_IDLE;
          end else begin
            inc     = 1'b1;
            state_n = ST_ISSUE;
          end
        end
`ifdef ITER_TIMEOUT_EN
        else if (to_cnt == TW'(TO_CYC - 1)) begin
          err_n   = 1'b1;
          en_n    = 1'b0;
          busy_n  = 1'b0;
          state_n = ST_IDLE;
        end else begin
          to_n = to_cnt + TW'(1);
        end
`endif
      end
      default: state_n = ST_IDLE;
    endcase
    // abort wins over a same-cycle match or timeout
    if (abort && busy) begin
      state_n = ST_IDLE;
      en_n    = 1'b0;
      busy_n  = 1'b0;
      step_n  = 1'b0;
      done_n  = 1'b0;
      idx_n   = step_idx;
      clr     = 1'b1;
      inc     = 1'b0;
`ifdef ITER_TIMEOUT_EN
      err_n   = err;
      to_n    = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      en       <= 1'b0;
      M        <= '0;
      busy     <= 1'b0;
      step     <= 1'b0;
      step_idx <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      en       <= en_n;
      M        <= m_n;
      busy     <= busy_n;
      step     <= step_n;
      step_idx <= idx_n;
      done     <= done_n;
    end
  end

`ifdef ITER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err    <= 1'b0;
      to_cnt <= '0;
    end else begin
      err    <= err_n;
      to_cnt <= to_n;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
